fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one SYNC_FIFO write port among 2**ID_W producers.
- Grants one requester at a time for a burst of up to MAX_BURST words.
- Drives the FIFO write enable and data, and never writes while the FIFO reports full, so the FIFO overflow flag stays low.
- Sits directly in front of SYNC_FIFO's i_WR_EN/i_WR_DATA/o_FULL.

Parameters:
- WIDTH, 8: data word width; must match the FIFO WIDTH.
- ID_W, 2: requester index width; N_REQ = 2**ID_W, so 4 requesters by default.
- MAX_BURST, 4: maximum words written per grant, legal range 1..255.

Ports:
- i_CLK  in  1  single clock, rising edge.
- i_RESET  in  1  synchronous, active-high reset.
- i_REQ  in  N_REQ  bit k high means requester k has a word on its data slice.
- i_DATA  in  N_REQ*WIDTH  packed data; requester k uses [k*WIDTH +: WIDTH].
- o_GNT  out  N_REQ  registered one-hot grant, or all zero.
- o_ACK  out  N_REQ  combinational one-hot; bit k high means requester k's word is written at this clock edge.
- o_ACTIVE_ID  out  ID_W  registered index of the granted requester (0 when idle).
- o_BUSY  out  1  high while in GRANT.
- i_FIFO_FULL  in  1  from FIFO o_FULL.
- o_FIFO_WR_EN  out  1  to FIFO i_WR_EN.
- o_FIFO_WR_DATA  out  WIDTH  to FIFO i_WR_DATA.

Behaviour:
- Clocking and reset: one clock, i_CLK. i_RESET is synchronous and active-high.
- Reset state: state=IDLE, o_GNT=0, o_ACTIVE_ID=0, o_BUSY=0, rr_ptr=0, burst_cnt=0.
  - Because of these register values, o_FIFO_WR_EN=0 and o_ACK=0 in the cycle after reset.
  - Reset mid-burst aborts the grant. No partial-state write follows.
- Transfer condition: xfer = o_BUSY & i_REQ[o_ACTIVE_ID] & ~i_FIFO_FULL.
  - o_FIFO_WR_EN = xfer.
  - o_ACK = xfer ? one-hot(o_ACTIVE_ID) : 0.
  - o_FIFO_WR_DATA = i_DATA slice of o_ACTIVE_ID, driven even when xfer=0.
- Handshake: a requester holds i_REQ high and its data stable until it sees o_ACK. After an ACK edge it may present its next word or drop i_REQ.
- State IDLE:
  - If i_REQ is non-zero, the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - Next cycle: state=GRANT, o_GNT=one-hot(winner), o_ACTIVE_ID=winner, burst_cnt=0.
  - If i_REQ is zero, stay in IDLE.
  - Latency from request to first write is 1 cycle after the i_REQ sample.
- State GRANT:
  - Each xfer increments burst_cnt.
  - Release condition: (xfer & burst_cnt==MAX_BURST-1), or (~i_REQ[o_ACTIVE_ID]).
  - On release: next state IDLE, o_GNT=0, rr_ptr = o_ACTIVE_ID+1 (wraps at N_REQ), burst_cnt=0.
  - On release the arbiter always spends 1 IDLE cycle (arbitration bubble) before the next grant.
- FIFO full during GRANT: grant held, no write, burst_cnt frozen. Transfers resume in the first cycle i_FIFO_FULL is low. There is no timeout.
- Requests from non-granted requesters are ignored until the next IDLE arbitration. Requests arriving mid-burst never preempt.
- Fairness: a continuously requesting producer waits at most (N_REQ-1)*(MAX_BURST+1) write-free cycles plus any FIFO-full stall cycles.
- burst_cnt width is 8 bits and never exceeds MAX_BURST-1. rr_ptr is ID_W bits and wraps naturally.

Test Plan:
- Reset: hold i_RESET 2 cycles with i_REQ=4'b1111 → o_GNT=0, o_FIFO_WR_EN=0, o_BUSY=0, o_ACTIVE_ID=0. After release, the first grant goes to requester 0.
- Single requester: requester 1 streams 6 words 0x1A..0x1F with MAX_BURST=4 →
  - o_GNT=4'b0010 one cycle after i_REQ rises.
  - Writes 0x1A–0x1D on 4 consecutive cycles, then 1 IDLE cycle.
  - Regrant, then writes 0x1E and 0x1F.
  - FIFO COUNT=6 at the end.
- Round robin: all 4 requesters continuously requesting, each with distinct data (0x10+k*0x10+n) → grant order 0,1,2,3,0. Exactly 4 writes per grant with 1 bubble between grants, and FIFO readout matches that order.
- Full stall: force i_FIFO_FULL=1 after 2 writes of a burst for 3 cycles → o_FIFO_WR_EN=0 and o_ACK=0 for 3 cycles, o_GNT unchanged. Writes 3 and 4 follow, then release. FIFO OF stays 0.
- Early release: requester 2 drops i_REQ after 2 ACKs → o_GNT=0 the next cycle; with requesters 2 and 3 both requesting at the following arbitration, requester 3 wins, since rr_ptr=3.
- Reset mid-burst: assert i_RESET after 1 write of a 4-word burst → o_GNT=0 and o_FIFO_WR_EN=0 on the next edge. After release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter that shares one SYNC_FIFO write
//               port among 2**ID_W producers, never writing while full.
// Revision    : 1.0
// ============================================================================
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int ID_W      = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                          i_CLK,
    input  logic                          i_RESET,
    input  logic [(2**ID_W)-1:0]          i_REQ,
    input  logic [(2**ID_W)*WIDTH-1:0]    i_DATA,
    output logic [(2**ID_W)-1:0]          o_GNT,
    output logic [(2**ID_W)-1:0]          o_ACK,
    output logic [ID_W-1:0]               o_ACTIVE_ID,
    output logic                          o_BUSY,
    input  logic                          i_FIFO_FULL,
    output logic                          o_FIFO_WR_EN,
    output logic [WIDTH-1:0]              o_FIFO_WR_DATA
);

    localparam int         N_REQ       = 2 ** ID_W;
    localparam logic [7:0] C_LAST_BEAT = 8'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]        burst_q, burst_d;

    logic              w_busy;
    logic              w_xfer;
    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic [ID_W-1:0]   w_idx;

    assign w_busy         = (state_q == ST_GRANT);
    assign w_xfer         = w_busy & i_REQ[id_q] & ~i_FIFO_FULL;
    assign o_FIFO_WR_EN   = w_xfer;
    assign o_ACK          = w_xfer ? (N_REQ'(1) << id_q) : '0;
    assign o_FIFO_WR_DATA = i_DATA[id_q*WIDTH +: WIDTH];
    assign o_GNT          = gnt_q;
    assign o_ACTIVE_ID    = id_q;
    assign o_BUSY         = w_busy;

    // Scan starting at rr_ptr; the ID_W-bit index wraps modulo N_REQ for free.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = rr_ptr_q + ID_W'(i);
            if (!w_found && i_REQ[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        case (state_q)
            ST_IDLE: begin
                if (w_found) begin
                    state_d = ST_GRANT;
                    gnt_d   = N_REQ'(1) << w_win;
                    id_d    = w_win;
                    burst_d = 8'd0;
                end
            end
            ST_GRANT: begin
                if (w_xfer) begin
                    burst_d = burst_q + 8'd1;
                end
                // A full FIFO only freezes the burst; releasing needs a final beat or a dropped request.
                if ((w_xfer && (burst_q == C_LAST_BEAT)) || !i_REQ[id_q]) begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    id_d     = '0;
                    rr_ptr_d = id_q + ID_W'(1);
                    burst_d  = 8'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            id_q     <= '0;
            rr_ptr_q <= '0;
            burst_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            id_q     <= id_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Directed and randomized self-checking bench for fifo_wr_arbiter.
// Revision    : 1.0
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int WIDTH     = 8;
    localparam int ID_W      = 2;
    localparam int N         = 4;
    localparam int MAX_BURST = 4;

    logic               clk = 1'b0;
    logic               i_RESET;
    logic [N-1:0]       i_REQ;
    logic [N*WIDTH-1:0] i_DATA;
    logic [N-1:0]       o_GNT;
    logic [N-1:0]       o_ACK;
    logic [ID_W-1:0]    o_ACTIVE_ID;
    logic               o_BUSY;
    logic               i_FIFO_FULL;
    logic               o_FIFO_WR_EN;
    logic [WIDTH-1:0]   o_FIFO_WR_DATA;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .ID_W(ID_W), .MAX_BURST(MAX_BURST)) dut (
        .i_CLK(clk), .i_RESET(i_RESET), .i_REQ(i_REQ), .i_DATA(i_DATA),
        .o_GNT(o_GNT), .o_ACK(o_ACK), .o_ACTIVE_ID(o_ACTIVE_ID), .o_BUSY(o_BUSY),
        .i_FIFO_FULL(i_FIFO_FULL), .o_FIFO_WR_EN(o_FIFO_WR_EN),
        .o_FIFO_WR_DATA(o_FIFO_WR_DATA)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0]   wq [N][$];
    int                 n_checks = 0;
    int                 n_err    = 0;
    int                 cyc      = 0;
    logic [N-1:0]       drv_req;
    logic [N*WIDTH-1:0] drv_data;
    logic               drv_full;
    logic               drv_rst  = 1'b1;
    logic [N-1:0]       s_ack;
    logic               s_wen;
    logic [WIDTH-1:0]   s_wd;
    int                 log_id[$];
    int                 log_data[$];
    int                 log_cyc[$];
    int                 fifo_cnt;
    bit                 of_flag;
    int                 m_owner = -1;
    int                 m_ptr   = 0;
    int                 m_cnt   = 0;

    task automatic drive(input bit full);
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            drv_req[k] = (wq[k].size() > 0);
            if (wq[k].size() > 0) drv_data[k*WIDTH +: WIDTH] = wq[k][0];
            else                  drv_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
        drv_full    = full;
        i_REQ       = drv_req;
        i_DATA      = drv_data;
        i_FIFO_FULL = full;
        i_RESET     = drv_rst;
        #1;
        s_ack = o_ACK;
        s_wen = o_FIFO_WR_EN;
        s_wd  = o_FIFO_WR_DATA;
    endtask

    // Producers react to ACK; reference arbiter advances by its own rules.
    task automatic advance();
        bit x;
        @(posedge clk);
        cyc++;
        if (s_wen) begin
            log_id.push_back(int'(o_ACTIVE_ID));
            log_data.push_back(int'(s_wd));
            log_cyc.push_back(cyc);
            fifo_cnt++;
            if (drv_full) of_flag = 1'b1;
        end
        for (int k = 0; k < N; k++)
            if (s_ack[k] && wq[k].size() > 0) void'(wq[k].pop_front());
        if (drv_rst) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            for (int i = 0; i < N; i++) begin
                if (m_owner < 0 && drv_req[(m_ptr + i) % N]) begin
                    m_owner = (m_ptr + i) % N;
                    m_cnt   = 0;
                end
            end
        end else begin
            x = drv_req[m_owner] && !drv_full;
            if (x) m_cnt++;
            if ((x && m_cnt == MAX_BURST) || !drv_req[m_owner]) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic reset_dut();
        drv_rst = 1'b1;
        drive(1'b0);
        advance();
        drv_rst = 1'b0;
        log_id.delete(); log_data.delete(); log_cyc.delete();
        fifo_cnt = 0;
        of_flag  = 1'b0;
    endtask

    task automatic flush();
        for (int k = 0; k < N; k++) wq[k].delete();
        repeat (3) begin drive(1'b0); advance(); end
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 4; j++) wq[k].push_back(WIDTH'(8'hC0 + k*4 + j));
        drv_rst = 1'b1;
        drive(1'b0);
        advance();
        repeat (2) begin
            drive(1'b0);
            n_checks++; if (o_GNT !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b exp 0000", o_GNT); end
            n_checks++; if (o_FIFO_WR_EN !== 1'b0) begin n_err++; $display("FAIL reset_wr_en got %b exp 0", o_FIFO_WR_EN); end
            n_checks++; if (o_BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", o_BUSY); end
            n_checks++; if (o_ACTIVE_ID !== 2'd0) begin n_err++; $display("FAIL reset_id got %0d exp 0", o_ACTIVE_ID); end
            advance();
        end
        drv_rst = 1'b0;
        drive(1'b0);
        advance();
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b0001) begin n_err++; $display("FAIL reset_first_gnt got %b exp 0001", o_GNT); end
        n_checks++; if (o_BUSY !== 1'b1) begin n_err++; $display("FAIL reset_first_busy got %b exp 1", o_BUSY); end
        advance();
        flush();
    endtask

    task automatic test_single();
        int off[6];
        off = '{0, 1, 2, 3, 5, 6};
        reset_dut();
        for (int j = 0; j < 6; j++) wq[1].push_back(WIDTH'(8'h1A + j));
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b0000) begin n_err++; $display("FAIL single_idle_gnt got %b exp 0000", o_GNT); end
        advance();
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b0010) begin n_err++; $display("FAIL single_gnt got %b exp 0010", o_GNT); end
        advance();
        for (int c = 0; c < 30 && log_id.size() < 6; c++) begin drive(1'b0); advance(); end
        n_checks++; if (log_id.size() != 6) begin n_err++; $display("FAIL single_nwrites got %0d exp 6", log_id.size()); end
        for (int i = 0; i < 6 && i < log_id.size(); i++) begin
            n_checks++; if (log_data[i] != 8'h1A + i) begin n_err++; $display("FAIL single_data[%0d] got %0h exp %0h", i, log_data[i], 8'h1A + i); end
            n_checks++; if (log_id[i] != 1) begin n_err++; $display("FAIL single_id[%0d] got %0d exp 1", i, log_id[i]); end
            n_checks++; if (log_cyc[i] - log_cyc[0] != off[i]) begin n_err++; $display("FAIL single_timing[%0d] got %0d exp %0d", i, log_cyc[i] - log_cyc[0], off[i]); end
        end
        n_checks++; if (fifo_cnt != 6) begin n_err++; $display("FAIL single_count got %0d exp 6", fifo_cnt); end
        flush();
    endtask

    task automatic test_round_robin();
        int g, j, k, n;
        reset_dut();
        for (int r = 0; r < N; r++)
            for (int w = 0; w < 8; w++) wq[r].push_back(WIDTH'(16 + r*16 + w));
        for (int c = 0; c < 80 && log_id.size() < 20; c++) begin drive(1'b0); advance(); end
        n_checks++; if (log_id.size() != 20) begin n_err++; $display("FAIL rr_nwrites got %0d exp 20", log_id.size()); end
        for (int i = 0; i < 20 && i < log_id.size(); i++) begin
            g = i / 4; j = i % 4; k = g % 4; n = (g / 4) * 4 + j;
            n_checks++; if (log_id[i] != k) begin n_err++; $display("FAIL rr_id[%0d] got %0d exp %0d", i, log_id[i], k); end
            n_checks++; if (log_data[i] != 16 + k*16 + n) begin n_err++; $display("FAIL rr_data[%0d] got %0h exp %0h", i, log_data[i], 16 + k*16 + n); end
            n_checks++; if (log_cyc[i] - log_cyc[0] != g*5 + j) begin n_err++; $display("FAIL rr_timing[%0d] got %0d exp %0d", i, log_cyc[i] - log_cyc[0], g*5 + j); end
        end
        flush();
    endtask

    task automatic test_full_stall();
        int  off[4];
        int  stall;
        bit  full;
        off   = '{0, 1, 5, 6};
        stall = 0;
        reset_dut();
        for (int w = 0; w < 4; w++) wq[0].push_back(WIDTH'(8'hA0 + w));
        for (int c = 0; c < 30 && log_id.size() < 4; c++) begin
            full = (log_id.size() == 2 && stall < 3);
            drive(full);
            if (full) begin
                stall++;
                n_checks++; if (o_FIFO_WR_EN !== 1'b0) begin n_err++; $display("FAIL stall_wr_en got %b exp 0", o_FIFO_WR_EN); end
                n_checks++; if (o_ACK !== 4'b0000) begin n_err++; $display("FAIL stall_ack got %b exp 0000", o_ACK); end
                n_checks++; if (o_GNT !== 4'b0001) begin n_err++; $display("FAIL stall_gnt got %b exp 0001", o_GNT); end
            end
            advance();
        end
        n_checks++; if (log_id.size() != 4) begin n_err++; $display("FAIL stall_nwrites got %0d exp 4", log_id.size()); end
        for (int i = 0; i < 4 && i < log_id.size(); i++) begin
            n_checks++; if (log_data[i] != 8'hA0 + i) begin n_err++; $display("FAIL stall_data[%0d] got %0h exp %0h", i, log_data[i], 8'hA0 + i); end
            n_checks++; if (log_cyc[i] - log_cyc[0] != off[i]) begin n_err++; $display("FAIL stall_timing[%0d] got %0d exp %0d", i, log_cyc[i] - log_cyc[0], off[i]); end
        end
        n_checks++; if (of_flag !== 1'b0) begin n_err++; $display("FAIL stall_overflow got %b exp 0", of_flag); end
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b0000) begin n_err++; $display("FAIL stall_release got %b exp 0000", o_GNT); end
        advance();
        flush();
    endtask

    task automatic test_early_release();
        reset_dut();
        wq[2].push_back(8'h21);
        wq[2].push_back(8'h22);
        for (int c = 0; c < 20 && log_id.size() < 2; c++) begin drive(1'b0); advance(); end
        n_checks++; if (log_id.size() != 2) begin n_err++; $display("FAIL early_nwrites got %0d exp 2", log_id.size()); end
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b0100) begin n_err++; $display("FAIL early_hold got %b exp 0100", o_GNT); end
        advance();
        wq[2].push_back(8'h23);
        wq[3].push_back(8'h31);
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b0000) begin n_err++; $display("FAIL early_drop got %b exp 0000", o_GNT); end
        n_checks++; if (o_BUSY !== 1'b0) begin n_err++; $display("FAIL early_busy got %b exp 0", o_BUSY); end
        advance();
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b1000) begin n_err++; $display("FAIL early_next got %b exp 1000", o_GNT); end
        n_checks++; if (o_ACTIVE_ID !== 2'd3) begin n_err++; $display("FAIL early_id got %0d exp 3", o_ACTIVE_ID); end
        advance();
        flush();
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        wq[2].push_back(8'h55);
        for (int c = 0; c < 20 && log_id.size() < 1; c++) begin drive(1'b0); advance(); end
        repeat (2) begin drive(1'b0); advance(); end
        for (int w = 0; w < 4; w++) wq[1].push_back(WIDTH'(8'h60 + w));
        for (int c = 0; c < 20 && log_id.size() < 2; c++) begin drive(1'b0); advance(); end
        n_checks++; if (log_id.size() != 2 || log_id[log_id.size()-1] != 1) begin n_err++; $display("FAIL midrst_setup got %0d writes exp 2", log_id.size()); end
        drv_rst = 1'b1;
        drive(1'b0);
        advance();
        drv_rst = 1'b0;
        wq[3].push_back(8'h77);
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b0000) begin n_err++; $display("FAIL midrst_gnt got %b exp 0000", o_GNT); end
        n_checks++; if (o_FIFO_WR_EN !== 1'b0) begin n_err++; $display("FAIL midrst_wr_en got %b exp 0", o_FIFO_WR_EN); end
        n_checks++; if (o_ACK !== 4'b0000) begin n_err++; $display("FAIL midrst_ack got %b exp 0000", o_ACK); end
        n_checks++; if (o_ACTIVE_ID !== 2'd0) begin n_err++; $display("FAIL midrst_id got %0d exp 0", o_ACTIVE_ID); end
        advance();
        drive(1'b0);
        n_checks++; if (o_GNT !== 4'b0010) begin n_err++; $display("FAIL midrst_regrant got %b exp 0010", o_GNT); end
        advance();
        flush();
    endtask

    task automatic test_random();
        logic [N-1:0]     e_gnt, e_ack;
        logic [ID_W-1:0]  e_id;
        logic             e_busy, e_x;
        logic [WIDTH-1:0] e_wd;
        bit               full;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++)
                if (wq[k].size() == 0 && $urandom_range(0, 2) == 0) wq[k].push_back(WIDTH'($urandom));
            full    = ($urandom_range(0, 4) == 0);
            drv_rst = ($urandom_range(0, 99) == 0);
            drive(full);
            e_busy = (m_owner >= 0);
            e_id   = e_busy ? ID_W'(m_owner) : '0;
            e_gnt  = e_busy ? (N'(1) << m_owner) : '0;
            e_x    = e_busy && drv_req[e_id] && !full;
            e_ack  = e_x ? (N'(1) << m_owner) : '0;
            e_wd   = drv_data[e_id*WIDTH +: WIDTH];
            n_checks++; if (o_GNT !== e_gnt) begin n_err++; $display("FAIL rand_gnt c%0d got %b exp %b", c, o_GNT, e_gnt); end
            n_checks++; if (o_ACTIVE_ID !== e_id) begin n_err++; $display("FAIL rand_id c%0d got %0d exp %0d", c, o_ACTIVE_ID, e_id); end
            n_checks++; if (o_BUSY !== e_busy) begin n_err++; $display("FAIL rand_busy c%0d got %b exp %b", c, o_BUSY, e_busy); end
            n_checks++; if (o_ACK !== e_ack) begin n_err++; $display("FAIL rand_ack c%0d got %b exp %b", c, o_ACK, e_ack); end
            n_checks++; if (o_FIFO_WR_EN !== e_x) begin n_err++; $display("FAIL rand_wr_en c%0d got %b exp %b", c, o_FIFO_WR_EN, e_x); end
            n_checks++; if (o_FIFO_WR_DATA !== e_wd) begin n_err++; $display("FAIL rand_wr_data c%0d got %0h exp %0h", c, o_FIFO_WR_DATA, e_wd); end
            advance();
            drv_rst = 1'b0;
        end
        n_checks++; if (of_flag !== 1'b0) begin n_err++; $display("FAIL rand_overflow got %b exp 0", of_flag); end
        flush();
    endtask

    initial begin
        i_RESET     = 1'b1;
        i_REQ       = '0;
        i_DATA      = '0;
        i_FIFO_FULL = 1'b0;
        drv_full    = 1'b0;
        s_ack       = '0;
        s_wen       = 1'b0;
        s_wd        = '0;
        fifo_cnt    = 0;
        of_flag     = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_early_release();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
